// File: rtl/ysyx_sq_pkg.sv
// Shared types and lane helpers for the committed-store queue.
// Entries are stored at the widest XLEN (64); narrower instances use the low bits.
package ysyx_sq_pkg;

  typedef enum logic [1:0] {
    BYTE  = 2'b00,
    HALF  = 2'b01,
    WORD  = 2'b10,
    DWORD = 2'b11
  } sq_size_e;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [7:0]  strb;
    logic [63:0] data;
  } sq_entry_t;

  function automatic logic [7:0] sq_strb(input sq_size_e size, input logic [2:0] offset);
    logic [7:0] m;
    case (size)
      BYTE:    m = 8'h01;
      HALF:    m = 8'h03;
      WORD:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << offset;
  endfunction

  function automatic logic [63:0] sq_lane_data(input logic [63:0] data, input logic [2:0] offset);
    return data << {offset, 3'b000};
  endfunction

endpackage

// File: rtl/ysyx_sq_fwd.sv
// Store-to-load forwarding: per requested lane, the youngest valid matching entry wins.
// Purely combinational; walks entries from head (oldest) towards tail (youngest).
module ysyx_sq_fwd
  import ysyx_sq_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SQ_SIZE = 4,
  parameter int FWD_EN  = 1
) (
  input  sq_entry_t                      entries [SQ_SIZE],
  input  logic [$clog2(SQ_SIZE)-1:0]     head,
  input  logic                           ld_valid,
  input  logic [XLEN-1:0]                ld_addr,
  input  logic [7:0]                     ld_rstrb,
  input  logic                           conflict,
  output logic                           fwd_hit,
  output logic [XLEN-1:0]                fwd_data,
  output logic                           fwd_stall
);
  localparam int PW = $clog2(SQ_SIZE);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'((XLEN / 8) - 1);
  localparam logic [7:0] LANE_MASK = (XLEN == 64) ? 8'hFF : 8'h0F;

  logic [7:0]      req;
  logic [7:0]      covered;
  logic [63:0]     merged;
  logic [PW-1:0]   idx;
  logic [63:0]     word_addr;
  logic            full_cover;
  logic            partial;

  always_comb begin
    req        = ld_rstrb & LANE_MASK;
    word_addr  = 64'(ld_addr & ALIGN_MASK);
    covered    = '0;
    merged     = '0;
    idx        = '0;
    if (FWD_EN != 0) begin
      // Later (younger) matches overwrite earlier ones lane by lane.
      for (int i = 0; i < SQ_SIZE; i++) begin
        idx = head + PW'(i);
        if (entries[idx].valid && entries[idx].addr == word_addr) begin
          for (int b = 0; b < 8; b++) begin
            if (req[b] && entries[idx].strb[b]) begin
              covered[b]        = 1'b1;
              merged[b*8 +: 8]  = entries[idx].data[b*8 +: 8];
            end
          end
        end
      end
    end
    full_cover = (req != '0) && (covered == req);
    partial    = (covered != '0) && (covered != req);
    fwd_stall  = ld_valid && (conflict || partial);
    fwd_hit    = ld_valid && !fwd_stall && full_cover;
    fwd_data   = fwd_hit ? merged[XLEN-1:0] : '0;
  end

endmodule

// File: rtl/ysyx_store_queue.sv
// Committed-store queue: in-order drain to the LSU store channel plus byte-lane forwarding.
// Handshake: a store moves only on a cycle where valid and ready are both high; the offer stays stable until then.
module ysyx_store_queue
  import ysyx_sq_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SQ_SIZE = 4,
  parameter int FWD_EN  = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [4:0]                 enq_alu,
  input  logic [XLEN-1:0]            enq_waddr,
  input  logic [XLEN-1:0]            enq_wdata,
  output logic                       awvalid,
  output logic                       wvalid,
  output logic [XLEN-1:0]            awaddr,
  output logic [7:0]                 wstrb,
  output logic [XLEN-1:0]            wdata,
  input  logic                       wready,
  input  logic                       ld_valid,
  input  logic [XLEN-1:0]            ld_addr,
  input  logic [7:0]                 ld_rstrb,
  output logic                       fwd_hit,
  output logic [XLEN-1:0]            fwd_data,
  output logic                       fwd_stall,
  output logic                       empty,
  output logic [$clog2(SQ_SIZE):0]   count
);
  localparam int PW = $clog2(SQ_SIZE);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(XLEN / 8);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'((XLEN / 8) - 1);
  localparam logic [7:0] LANE_MASK = (XLEN == 64) ? 8'hFF : 8'h0F;
  localparam logic [CW-1:0] FULL = CW'(SQ_SIZE);

  sq_entry_t       q [SQ_SIZE];
  sq_entry_t       enq_entry;
  sq_entry_t       head_entry;
  sq_size_e        enq_size;
  logic [2:0]      enq_off;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic            enq_fire;
  logic            deq_fire;
  logic            conflict;
  logic            unused_alu;

  assign unused_alu = ^enq_alu[4:2];

  assign enq_ready = (count != FULL);
  assign empty     = (count == '0);
  assign awvalid   = !empty;
  assign wvalid    = awvalid;
  assign enq_fire  = enq_valid && enq_ready;
  assign deq_fire  = awvalid && wready;

  // Lane strobe and shifted data are fixed at enqueue so drain and forwarding stay cheap.
  always_comb begin
    enq_size = sq_size_e'(enq_alu[1:0]);
    if (XLEN == 32 && enq_size == DWORD) enq_size = WORD;
    enq_off         = 3'(enq_waddr[OW-1:0]);
    enq_entry.valid = 1'b1;
    enq_entry.addr  = 64'(enq_waddr & ALIGN_MASK);
    enq_entry.strb  = sq_strb(enq_size, enq_off) & LANE_MASK;
    enq_entry.data  = sq_lane_data(64'(enq_wdata), enq_off);
  end

  assign head_entry = q[head];
  assign awaddr = awvalid ? head_entry.addr[XLEN-1:0] : '0;
  assign wstrb  = awvalid ? head_entry.strb : '0;
  assign wdata  = awvalid ? head_entry.data[XLEN-1:0] : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SQ_SIZE; i++) q[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_fire) begin
        q[tail] <= enq_entry;
        tail    <= tail + 1'b1;
      end
      if (deq_fire) begin
        q[head].valid <= 1'b0;
        head          <= head + 1'b1;
      end
      case ({enq_fire, deq_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A store being enqueued this cycle is not yet searchable, so the load must wait.
  assign conflict = ld_valid && enq_valid &&
                    ((enq_waddr & ALIGN_MASK) == (ld_addr & ALIGN_MASK));

  ysyx_sq_fwd #(
    .XLEN    (XLEN),
    .SQ_SIZE (SQ_SIZE),
    .FWD_EN  (FWD_EN)
  ) u_fwd (
    .entries   (q),
    .head      (head),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .ld_rstrb  (ld_rstrb),
    .conflict  (conflict),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
    .fwd_stall (fwd_stall)
  );

endmodule

// File: doc/ysyx_store_queue.md
# ysyx_store_queue

Parametrised committed-store queue between the commit stage's store channel and the LSU store bus. It buffers up to `SQ_SIZE` retired stores, drains them in order onto the store channel of the LSU bus with a valid/ready handshake, and serves byte-granular store-to-load forwarding to the load path. It replaces the single-entry store latch and generalises it in depth, data width and forwarding.

## Interface
- `XLEN`, 32: data/address width; 32 or 64.
- `SQ_SIZE`, 4: entries; power of two, ≥2.
- `FWD_EN`, 1: 0 makes every forwarding query miss, except the conflict path below still raises `fwd_stall`.
- `clock`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-low reset.
- `enq_valid`  in  1  committed store present.
- `enq_ready`  out  1  `count != SQ_SIZE`.
- `enq_alu`  in  5  store op; `[1:0]` size: 00 byte, 01 half, 10 word, 11 dword (XLEN=64 only; at XLEN=32 treated as word).
- `enq_waddr`  in  XLEN  byte address.
- `enq_wdata`  in  XLEN  store data, value in low bits.
- `awvalid`, `wvalid`  out  1  head store offered; always equal.
- `awaddr`  out  XLEN  head address, aligned down to XLEN/8 bytes.
- `wstrb`  out  8  byte lanes; bits ≥ XLEN/8 are 0.
- `wdata`  out  XLEN  data shifted into lane position.
- `wready`  in  1  bus accepts head store.
- `ld_valid`  in  1  forwarding query.
- `ld_addr`  in  XLEN  load address, aligned down to XLEN/8 bytes.
- `ld_rstrb`  in  8  requested byte lanes.
- `fwd_hit`  out  1  all requested lanes supplied by queue.
- `fwd_data`  out  XLEN  merged bytes; unrequested lanes 0.
- `fwd_stall`  out  1  partial coverage or same-cycle enqueue conflict.
- `empty`  out  1  `count == 0`; used by fence.i/fence drain.
- `count`  out  clog2(SQ_SIZE)+1  occupancy.

## Operation
- Entry contents: valid, aligned word address, lane strobe, lane-shifted data. Strobe and data are computed at enqueue: mask by size, shifted by `enq_waddr[clog2(XLEN/8)-1:0]`.
- Circular buffer with head/tail pointers of clog2(SQ_SIZE) bits that wrap modulo SQ_SIZE. Full/empty are derived from `count`.
- Enqueue: on `enq_valid && enq_ready` the store is written at tail, tail advances, and count increments.
- Drain: while non-empty, the head entry drives `awvalid=wvalid=1` with its `awaddr/wstrb/wdata`. These are held stable until `wready`. On `wready` the head is invalidated, head advances, and count decrements. Only one store is outstanding; this is the head.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers move. When full, `enq_ready=0` even if `wready` is high that cycle; there is no bypass.
- Forwarding is combinational:
  - For each lane requested in `ld_rstrb`, take the youngest valid entry whose word address equals `ld_addr` and whose strobe has that lane set.
  - All requested lanes covered: `fwd_hit=1`, `fwd_data` merged from those entries.
  - Some lanes covered but not all: `fwd_stall=1`, `fwd_hit=0`.
  - No lanes covered: both 0, and the load goes to the bus.
  - The head entry remains forwardable until the cycle its `wready` handshake completes.
- Same-cycle conflict: if `ld_valid && enq_valid` and the word addresses match, `fwd_stall=1` regardless of coverage.
- When `ld_valid=0`, all forwarding outputs are 0.

## Timing
- Reset values (asynchronous, immediate on `reset` low): all entries invalid, head=tail=0, `count=0`, `empty=1`, `enq_ready=1`, `awvalid=wvalid=0`, `wstrb=0`, `awaddr=wdata=0`, forwarding outputs 0. A store in flight at reset is discarded.
- A store enqueued at edge N into an empty queue raises `awvalid` after edge N and can complete at edge N+1 at the earliest.
- Throughput is one store per cycle with `wready` held high.
- Forwarding sees an entry starting the cycle after its enqueue edge. The conflict stall covers the enqueue cycle itself.

## Structure
- Package `ysyx_sq_pkg` contains:
  - enum `sq_size_e`: BYTE/HALF/WORD/DWORD;
  - function `sq_strb(size, offset)` returning the 8-bit lane mask;
  - function `sq_lane_data(data, offset)`;
  - entry struct `sq_entry_t`.
- Sub-module `ysyx_sq_fwd` holds the combinational age-ordered lane-merge search, parametrised by XLEN and SQ_SIZE.

## Test plan
- Reset, then enqueue SB addr 0x8000_0003 data 0xAB → next cycle `awaddr=0x8000_0000`, `wstrb=0x08`, `wdata=0xAB00_0000`.
- Enqueue 4 stores with `wready=0` → `enq_ready=0`, `count=4`. Raise `wready` for 1 cycle → `count=3`, `enq_ready=1`. Stores drain in original order.
- Hold `wready=1` with `enq_valid` every cycle → `count` constant at 1 and one handshake per cycle.
- SW 0x1000 = 0x1122_3344, then SB 0x1001 = 0x55. Load `ld_addr=0x1000`, `ld_rstrb=0xF` → `fwd_hit=1`, `fwd_data=0x1122_5544`.
- SH 0x2000 = 0xBEEF, then load `rstrb=0xF` at 0x2000 → `fwd_stall=1`, `fwd_hit=0`. Load at 0x2004 → all forwarding outputs 0.
- With 3 entries queued and `awvalid` high, drop `reset` mid-cycle → `awvalid`, `count` and `empty` reach 0/0/1 without waiting for a clock edge. After release, an enqueue lands at index 0.
